// File: rtl/pipe_pkg.sv
// Shared constants for the ((a+b)+(c-d))*d arithmetic pipe and its result collector.
// Keeping them in one place keeps the pipe and the collector in agreement.
package pipe_pkg;

   localparam int unsigned PIPE_WIDTH      = 10;
   localparam int unsigned PIPE_LATENCY    = 3;
   localparam int unsigned PIPE_FIFO_DEPTH = 4;
   localparam int unsigned PIPE_ACC_WIDTH  = 16;
   localparam int unsigned DROP_CNT_WIDTH  = 8;

   typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

   // Per-cycle capture decision made by the collector.
   typedef struct packed {
      logic accept;
      logic drop;
      logic pop;
   } cap_ctl_t;

   function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
      return (v == '1) ? v : v + drop_cnt_t'(1);
   endfunction

endpackage

// File: rtl/pipe_fifo.sv
// Registered (non fall-through) synchronous FIFO with occupancy level.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pipe_fifo
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = PIPE_WIDTH,
   parameter int unsigned DEPTH = PIPE_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head is forced to zero while empty so stale storage never shows on dout.
   assign dout = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/pipe_result_collector.sv
// Aligns the arithmetic pipe output with its issue strobe, queues the results
// behind a valid/ready port and keeps a running sum plus a saturating drop count.
module pipe_result_collector
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH     = PIPE_WIDTH,
   parameter int unsigned LATENCY   = PIPE_LATENCY,
   parameter int unsigned DEPTH     = PIPE_FIFO_DEPTH,
   parameter int unsigned ACC_WIDTH = PIPE_ACC_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issue_valid,
   input  logic [WIDTH-1:0]         f_in,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   input  logic                     acc_clr,
   output logic [ACC_WIDTH-1:0]     acc,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic [7:0]               drop_cnt
);

   logic [LATENCY:0]   tag;
   logic               cap_en;
   logic               fifo_empty;
   cap_ctl_t           ctl;
   logic [ACC_WIDTH-1:0] f_ext;
   logic [ACC_WIDTH-1:0] acc_nxt;

   // tag[i] holds the issue strobe sampled i edges ago; the top bit marks the
   // cycle in which f_in carries that issue's result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag <= '0;
      end else begin
         tag <= {tag[LATENCY-1:0], issue_valid};
      end
   end

   assign cap_en = tag[LATENCY];

   always_comb begin
      ctl        = '0;
      ctl.pop    = out_valid && out_ready;
      ctl.accept = cap_en && (!full || ctl.pop);
      ctl.drop   = cap_en && full && !ctl.pop;
   end

   pipe_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ctl.accept),
      .din   (f_in),
      .pop   (ctl.pop),
      .dout  (out_data),
      .level (level),
      .full  (full),
      .empty (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign f_ext     = ACC_WIDTH'(f_in);

   // A clear coinciding with an accepted capture restarts the sum at that value.
   always_comb begin
      acc_nxt = acc;
      if (acc_clr) begin
         acc_nxt = ctl.accept ? f_ext : '0;
      end else if (ctl.accept) begin
         acc_nxt = acc + f_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         drop_cnt <= '0;
      end else begin
         acc <= acc_nxt;
         if (ctl.drop) begin
            drop_cnt <= sat_inc(drop_cnt);
         end
      end
   end

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector with a behavioural model of the arithmetic pipe.
module tb_pipe_result_collector;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic [9:0]  f_in;
   logic        out_ready;
   logic        out_valid;
   logic [9:0]  out_data;
   logic        acc_clr;
   logic [15:0] acc;
   logic [2:0]  level;
   logic        full;
   logic [7:0]  drop_cnt;

   logic [9:0]  f_new;
   logic [9:0]  fp [4];

   int n_vec;
   int n_err;

   pipe_result_collector #(
      .WIDTH     (10),
      .LATENCY   (3),
      .DEPTH     (4),
      .ACC_WIDTH (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .f_in        (f_in),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .acc_clr     (acc_clr),
      .acc         (acc),
      .level       (level),
      .full        (full),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pipe model: operands sampled at edge k, result presented after edge k+3.
   always @(posedge clk) begin
      fp[0] <= f_new;
      for (int i = 1; i < 4; i++) fp[i] <= fp[i-1];
   end
   assign f_in = fp[3];

   function automatic logic [9:0] fcalc(input int a, input int b, input int c, input int d);
      return 10'((a + b + (c - d)) * d);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_op(input int a, input int b, input int c, input int d);
      f_new       = fcalc(a, b, c, d);
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".out_valid"}, 32'(out_valid), 0);
      check({tag, ".out_data"},  32'(out_data),  0);
      check({tag, ".level"},     32'(level),     0);
      check({tag, ".full"},      32'(full),      0);
      check({tag, ".acc"},       32'(acc),       0);
      check({tag, ".drop_cnt"},  32'(drop_cnt),  0);
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      issue_valid = 1'b0;
      out_ready   = 1'b0;
      acc_clr     = 1'b0;
      f_new       = '0;
      #1;
      check_all_zero("reset");
      repeat (5) tick();
      rst_n = 1'b1;
      tick();

      // single issue, latency to out_valid
      out_ready = 1'b1;
      issue_op(3, 7, 8, 5);
      for (int i = 1; i <= 3; i++) check("single.early_valid", 32'(out_valid), 0);
      for (int i = 1; i <= 3; i++) ;
      tick(); check("single.pre4", 32'(out_valid), 0);
      tick(); tick();
      // after edge k+3 still empty
      check("single.pre_k3", 32'(out_valid), 0);
      tick();
      check("single.valid", 32'(out_valid), 1);
      check("single.data",  32'(out_data),  65);
      check("single.acc",   32'(acc),       65);
      check("single.level", 32'(level),     1);
      tick();
      check("single.level_after_pop", 32'(level), 0);
      check("single.valid_after_pop", 32'(out_valid), 0);

      // acc_clr alone
      acc_clr = 1'b1; tick(); acc_clr = 1'b0;
      check("clr_alone.acc", 32'(acc), 0);

      // back-to-back issues
      issue_op(3, 7, 8, 5);
      issue_op(1, 2, 9, 4);
      tick(); tick(); tick();
      check("b2b.valid0", 32'(out_valid), 1);
      check("b2b.data0",  32'(out_data),  65);
      tick();
      check("b2b.valid1", 32'(out_valid), 1);
      check("b2b.data1",  32'(out_data),  32);
      check("b2b.acc",    32'(acc),       97);
      tick();
      check("b2b.level_end", 32'(level), 0);

      // acc_clr together with a capture of 65
      issue_op(3, 7, 8, 5);
      tick(); tick(); tick();
      acc_clr = 1'b1; tick(); acc_clr = 1'b0;
      check("clr_cap.acc",   32'(acc),   65);
      check("clr_cap.level", 32'(level), 1);
      tick();
      check("clr_cap.level_end", 32'(level), 0);
      acc_clr = 1'b1; tick(); acc_clr = 1'b0;
      check("clr_alone2.acc", 32'(acc), 0);

      // overflow: 6 captures into a 4-deep FIFO with the sink stalled
      out_ready = 1'b0;
      repeat (6) issue_op(3, 7, 8, 5);
      tick(); tick(); tick(); tick();
      check("ovf.level",    32'(level),    4);
      check("ovf.full",     32'(full),     1);
      check("ovf.drop_cnt", 32'(drop_cnt), 2);
      check("ovf.acc",      32'(acc),      260);
      check("ovf.valid",    32'(out_valid), 1);
      tick();
      check("ovf.stall_data", 32'(out_data), 65);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("ovf.drain", 32'(out_data), 65);
         tick();
      end
      check("ovf.level_end", 32'(level),     0);
      check("ovf.full_end",  32'(full),      0);
      check("ovf.valid_end", 32'(out_valid), 0);

      // full FIFO with capture and pop in the same cycle
      out_ready = 1'b0;
      repeat (4) issue_op(3, 7, 8, 5);
      issue_op(1, 2, 9, 4);
      tick(); tick(); tick();
      check("fullpop.level_pre", 32'(level), 4);
      check("fullpop.full_pre",  32'(full),  1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("fullpop.level",    32'(level),    4);
      check("fullpop.drop_cnt", 32'(drop_cnt), 2);
      check("fullpop.acc",      32'(acc),      552);
      out_ready = 1'b1;
      check("fullpop.drain0", 32'(out_data), 65); tick();
      check("fullpop.drain1", 32'(out_data), 65); tick();
      check("fullpop.drain2", 32'(out_data), 65); tick();
      check("fullpop.drain3", 32'(out_data), 32); tick();
      check("fullpop.level_end", 32'(level), 0);

      // asynchronous reset with 3 queued and 2 in flight
      out_ready = 1'b0;
      repeat (5) issue_op(3, 7, 8, 5);
      tick(); tick();
      check("rst.level_pre", 32'(level), 3);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst.async");
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst.no_ghost_valid", 32'(out_valid), 0);
      end
      check("rst.level_end", 32'(level), 0);
      check("rst.acc_end",   32'(acc),   0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
